// File: rtl/exception_ctrl_pkg.sv
// Shared constants and types for the exception sequencer: cause/selector
// codes, vector byte addresses and the sequencer state encoding.
package exception_ctrl_pkg;

    // Cause codes; the same values drive the vector mux selector.
    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_OPC  = 2'd1;
    localparam logic [1:0] EXC_OVF  = 2'd2;
    localparam logic [1:0] EXC_DIV0 = 2'd3;

    // Memory locations holding the handler byte for each cause.
    localparam logic [7:0] VEC_OPC  = 8'd253;
    localparam logic [7:0] VEC_OVF  = 8'd254;
    localparam logic [7:0] VEC_DIV0 = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_FETCH,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Resolve simultaneous events: opcode beats overflow beats divide-by-zero.
    function automatic logic [1:0] prio_code(input logic opc, input logic ovf,
                                             input logic div0);
        logic [1:0] code;
        code = EXC_NONE;
        if (opc)
            code = EXC_OPC;
        else if (ovf)
            code = EXC_OVF;
        else if (div0)
            code = EXC_DIV0;
        return code;
    endfunction

endpackage

// File: rtl/exception_ctrl.sv
// Exception sequencer: saves the faulting PC, steers the vector mux to the
// handler byte, waits MEM_LAT cycles for memory and loads the handler PC.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int PC_ADJ  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chk_en,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_byte,
    output logic [3:0]  exc_sel,
    output logic        mem_rd,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        pc_load,
    output logic [31:0] pc_new,
    output logic        busy,
    output logic        exc_done
);

    localparam logic [3:0]  LAT_INIT = 4'(MEM_LAT);
    localparam logic [31:0] ADJ      = 32'(PC_ADJ);

    state_t      state_reg, state_next;
    logic [1:0]  code_reg;
    logic [1:0]  cause_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] epc_reg;
    logic [31:0] pc_new_reg;
    logic        accept;

    // Events only count at the check point and only while the sequencer is idle.
    assign accept = (state_reg == ST_IDLE) && chk_en &&
                    (exc_opcode || exc_ovf || exc_div0);

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Code latch, EPC/cause save, latency counter and handler byte capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_reg   <= EXC_NONE;
            cause_reg  <= EXC_NONE;
            cnt_reg    <= 4'd0;
            epc_reg    <= 32'd0;
            pc_new_reg <= 32'd0;
        end else begin
            if (accept)
                code_reg <= prio_code(exc_opcode, exc_ovf, exc_div0);
            if (state_reg == ST_SAVE) begin
                epc_reg   <= pc_in - ADJ;
                cause_reg <= code_reg;
                cnt_reg   <= LAT_INIT;
            end
            if (state_reg == ST_FETCH) begin
                cnt_reg <= cnt_reg - 4'd1;
                if (cnt_reg == 4'd1)
                    pc_new_reg <= {24'b0, mem_byte};
            end
        end
    end

    // Next-state logic; FETCH lasts exactly MEM_LAT cycles.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_SAVE;
            ST_SAVE:  state_next = ST_FETCH;
            ST_FETCH: if (cnt_reg == 4'd1) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state and code only (no path from exc_*).
    always_comb begin
        exc_sel  = 4'd0;
        mem_rd   = 1'b0;
        pc_load  = 1'b0;
        exc_done = 1'b0;
        busy     = (state_reg != ST_IDLE);
        unique case (state_reg)
            ST_SAVE:  exc_sel = {2'b00, code_reg};
            ST_FETCH: begin
                exc_sel = {2'b00, code_reg};
                mem_rd  = 1'b1;
            end
            ST_LOAD: begin
                exc_sel = {2'b00, code_reg};
                pc_load = 1'b1;
            end
            ST_DONE:  exc_done = 1'b1;
            default:  ;
        endcase
    end

    assign epc    = epc_reg;
    assign cause  = cause_reg;
    assign pc_new = pc_new_reg;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: table vectors, a reset-abort
// sequence and randomized transactions against a timeline reference model.
module tb_exception_ctrl;

    localparam int MEM_LAT = 2;
    localparam int SEQ_LEN = 3 + MEM_LAT;   // busy cycles per accepted exception

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chk_en = 1'b0;
    logic        exc_opcode = 1'b0;
    logic        exc_ovf = 1'b0;
    logic        exc_div0 = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic [7:0]  mem_byte = 8'd0;
    logic [3:0]  exc_sel;
    logic        mem_rd;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        pc_load;
    logic [31:0] pc_new;
    logic        busy;
    logic        exc_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state: architectural registers as seen after sequences.
    logic [31:0] epc_m = 32'd0;
    logic [1:0]  cause_m = 2'd0;
    logic [31:0] pcnew_m = 32'd0;

    typedef struct {
        logic        chk;
        logic        opc;
        logic        ovf;
        logic        div0;
        logic        inject;      // pulse div0 at the check point during FETCH
        logic [31:0] pc;
        logic [7:0]  mb;
        logic        exp_accept;
        logic [1:0]  exp_cause;
        logic [31:0] exp_epc;
        logic [31:0] exp_pc_new;
    } vec_t;

    vec_t vecs[7];

    exception_ctrl #(.MEM_LAT(MEM_LAT), .PC_ADJ(4)) dut (
        .clk(clk), .reset(reset), .chk_en(chk_en), .exc_opcode(exc_opcode),
        .exc_ovf(exc_ovf), .exc_div0(exc_div0), .pc_in(pc_in),
        .mem_byte(mem_byte), .exc_sel(exc_sel), .mem_rd(mem_rd), .epc(epc),
        .cause(cause), .pc_load(pc_load), .pc_new(pc_new), .busy(busy),
        .exc_done(exc_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s act=%h req=%h", name, act, exp);
    endtask

    function automatic logic [7:0] ctl_bus();
        return {exc_sel, mem_rd, pc_load, busy, exc_done};
    endfunction

    // Expected control outputs k cycles after the detecting edge, purely from
    // the documented timeline: SAVE at k=1, FETCH for MEM_LAT cycles, LOAD, DONE.
    function automatic logic [7:0] ctl_expect(input int k, input logic acc,
                                              input logic [1:0] code);
        logic [3:0] sel;
        logic rd, ld, bz, dn;
        sel = (acc && k >= 1 && k <= 2 + MEM_LAT) ? {2'b00, code} : 4'd0;
        rd  = acc && k >= 2 && k <= 1 + MEM_LAT;
        ld  = acc && k == 2 + MEM_LAT;
        bz  = acc && k >= 1 && k <= SEQ_LEN;
        dn  = acc && k == SEQ_LEN;
        return {sel, rd, ld, bz, dn};
    endfunction

    task automatic run_seq(input int id, input vec_t v);
        @(negedge clk);
        chk_en = v.chk; exc_opcode = v.opc; exc_ovf = v.ovf; exc_div0 = v.div0;
        pc_in = v.pc; mem_byte = v.mb;
        @(posedge clk);
        #1;
        chk_en = 1'b0; exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
        for (int k = 1; k <= SEQ_LEN + 1; k++) begin
            @(negedge clk);
            if (v.inject && k == 3) begin
                chk_en = 1'b0; exc_div0 = 1'b0;
            end
            check($sformatf("ctl[%0d] k=%0d", id, k), {24'd0, ctl_bus()},
                  {24'd0, ctl_expect(k, v.exp_accept, v.exp_cause)});
            if (v.exp_accept && k == 2 + MEM_LAT)
                check($sformatf("pc_new_at_load[%0d]", id), pc_new, v.exp_pc_new);
            if (v.inject && k == 2) begin
                chk_en = 1'b1; exc_div0 = 1'b1;
            end
        end
        check($sformatf("epc[%0d]", id), epc, v.exp_epc);
        check($sformatf("cause[%0d]", id), {30'd0, cause}, {30'd0, v.exp_cause});
        check($sformatf("pc_new[%0d]", id), pc_new, v.exp_pc_new);
        $display("txn %0d: chk=%0b opc=%0b ovf=%0b div0=%0b inj=%0b pc=%h mb=%h -> cause=%0d epc=%h pc_new=%h",
                 id, v.chk, v.opc, v.ovf, v.div0, v.inject, v.pc, v.mb, cause, epc, pc_new);
    endtask

    // Model update from the behavioural rules: accept only at the check point.
    task automatic model_apply(inout vec_t v);
        logic [1:0] code;
        code = v.opc ? 2'd1 : v.ovf ? 2'd2 : v.div0 ? 2'd3 : 2'd0;
        v.exp_accept = v.chk && (code != 2'd0);
        if (v.exp_accept) begin
            epc_m   = v.pc - 32'd4;
            cause_m = code;
            pcnew_m = {24'd0, v.mb};
        end
        v.exp_cause  = cause_m;
        v.exp_epc    = epc_m;
        v.exp_pc_new = pcnew_m;
    endtask

    initial begin
        vec_t v;
        //          chk opc ovf dv0 inj pc            mb     acc cause epc            pc_new
        vecs[0] = '{1, 1, 0, 0, 0, 32'h0000_0040, 8'h80, 1, 2'd1, 32'h0000_003C, 32'h80};
        vecs[1] = '{1, 0, 1, 1, 0, 32'h0000_1000, 8'h33, 1, 2'd2, 32'h0000_0FFC, 32'h33};
        vecs[2] = '{0, 0, 0, 1, 0, 32'h0000_2000, 8'h77, 0, 2'd2, 32'h0000_0FFC, 32'h33};
        vecs[3] = '{1, 0, 1, 0, 1, 32'h0000_0300, 8'h10, 1, 2'd2, 32'h0000_02FC, 32'h10};
        vecs[4] = '{1, 0, 0, 1, 0, 32'h0000_0400, 8'h44, 1, 2'd3, 32'h0000_03FC, 32'h44};
        vecs[5] = '{1, 0, 1, 0, 0, 32'h0000_0000, 8'hFF, 1, 2'd2, 32'hFFFF_FFFC, 32'hFF};
        vecs[6] = '{1, 1, 1, 1, 0, 32'h0000_0008, 8'h01, 1, 2'd1, 32'h0000_0004, 32'h01};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_ctl", {24'd0, ctl_bus()}, 32'd0);
        check("reset_regs", epc | pc_new | {30'd0, cause}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++)
            run_seq(i, vecs[i]);
        epc_m = vecs[6].exp_epc; cause_m = vecs[6].exp_cause; pcnew_m = vecs[6].exp_pc_new;

        // Reset asserted for one cycle in the middle of FETCH.
        @(negedge clk);
        chk_en = 1'b1; exc_opcode = 1'b1; pc_in = 32'h100; mem_byte = 8'h5A;
        @(posedge clk);
        #1;
        chk_en = 1'b0; exc_opcode = 1'b0;
        @(negedge clk);              // SAVE
        @(negedge clk);              // FETCH
        check("pre_reset_fetch", {24'd0, ctl_bus()}, {24'd0, ctl_expect(2, 1'b1, 2'd1)});
        reset = 1'b0;
        #1;
        check("midreset_ctl", {24'd0, ctl_bus()}, 32'd0);
        check("midreset_epc", epc, 32'd0);
        check("midreset_cause_pcnew", pc_new | {30'd0, cause}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        epc_m = 32'd0; cause_m = 2'd0; pcnew_m = 32'd0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle k=%0d", k), {24'd0, ctl_bus()} | pc_new, 32'd0);
        end
        $display("txn reset-abort: reset during FETCH -> outputs cleared, no pc_load");

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.chk    = ($urandom_range(0, 3) != 0);
            v.opc    = ($urandom_range(0, 3) == 0);
            v.ovf    = ($urandom_range(0, 2) == 0);
            v.div0   = ($urandom_range(0, 1) == 0);
            v.inject = ($urandom_range(0, 3) == 0);
            v.pc     = $urandom;
            v.mb     = 8'($urandom);
            model_apply(v);
            if (!v.exp_accept)
                v.inject = 1'b0;
            run_seq(100 + i, v);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
